// File: rtl/game_pkg.sv
// Shared definitions for the game datapath: direction codes, scheduler states
// and the priority helpers used by the move-command scheduler and engine FSM.
package game_pkg;

    localparam logic [2:0] DIR_NONE  = 3'b000;
    localparam logic [2:0] DIR_UP    = 3'b001;
    localparam logic [2:0] DIR_DOWN  = 3'b010;
    localparam logic [2:0] DIR_LEFT  = 3'b011;
    localparam logic [2:0] DIR_RIGHT = 3'b100;

    localparam int TILE_W = 4;

    typedef enum logic [1:0] {
        ARMED = 2'd0,
        LOCK  = 2'd1,
        HALT  = 2'd2
    } sched_state_t;

    // Rise vector bit order is {right, left, down, up}; lowest bit wins.
    function automatic logic [2:0] pick_dir(input logic [3:0] rise);
        if (rise[0])      return DIR_UP;
        else if (rise[1]) return DIR_DOWN;
        else if (rise[2]) return DIR_LEFT;
        else if (rise[3]) return DIR_RIGHT;
        else              return DIR_NONE;
    endfunction

    function automatic logic [1:0] extra_rises(input logic [3:0] rise);
        logic [2:0] n;
        n = {2'b0, rise[0]} + {2'b0, rise[1]} + {2'b0, rise[2]} + {2'b0, rise[3]};
        return (n == 3'd0) ? 2'd0 : 2'(n - 3'd1);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// DEPTH x W synchronous FIFO with flush; a push into a full FIFO is accepted
// only when a pop happens on the same edge.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/move_cmd_scheduler.sv
// Turns button presses into queued direction commands for the game engine.
// Optional auto-repeat of a held button is enabled with `define AUTOREPEAT_EN.
module move_cmd_scheduler
    import game_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int LOCKOUT = 8,
    parameter int REPEAT  = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   up,
    input  logic                   down,
    input  logic                   left,
    input  logic                   right,
    input  logic                   game_over,
    input  logic                   cmd_ready,
    output logic                   cmd_valid,
    output logic [2:0]             cmd_dir,
    output logic [$clog2(DEPTH):0] q_count,
    output logic [7:0]             drop_cnt,
    output sched_state_t           state
);
    localparam int LW = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT - 1);

    // Handshake: a command transfers on any edge where cmd_valid && cmd_ready;
    // cmd_dir holds while cmd_valid is high and cmd_ready is low.

    sched_state_t  state_n;
    logic [3:0]    btn;
    logic [3:0]    prev;
    logic [3:0]    rise;
    logic [LW-1:0] lock_cnt;
    logic [LW-1:0] lock_n;
    logic          push_req;
    logic [2:0]    push_dir;
    logic [1:0]    extra;
    logic          pop;
    logic          push;
    logic          push_drop;
    logic          full;
    logic          empty;
    logic [2:0]    head;
    logic [8:0]    drop_sum;
    logic          repeat_fire;

    assign btn  = {right, left, down, up};
    assign rise = btn & ~prev;

`ifdef AUTOREPEAT_EN
    localparam int HW = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    logic [HW-1:0] hold_cnt;
    logic [2:0]    last_dir;
    logic          held;

    always_comb begin
        held = 1'b0;
        case (last_dir)
            DIR_UP:    held = btn[0];
            DIR_DOWN:  held = btn[1];
            DIR_LEFT:  held = btn[2];
            DIR_RIGHT: held = btn[3];
            default:   held = 1'b0;
        endcase
    end

    assign repeat_fire = (state == ARMED) && (rise == 4'b0) && held &&
                         (hold_cnt == HW'(REPEAT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
            last_dir <= DIR_NONE;
        end else begin
            if (state == ARMED && rise != 4'b0) last_dir <= pick_dir(rise);
            // Counter only runs across uninterrupted ARMED cycles with the button held.
            if (state != ARMED || rise != 4'b0 || !held || repeat_fire)
                hold_cnt <= '0;
            else
                hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        lock_n   = lock_cnt;
        push_req = 1'b0;
        push_dir = DIR_NONE;
        extra    = 2'd0;
        case (state)
            ARMED: begin
                if (rise != 4'b0) begin
                    push_req = 1'b1;
                    push_dir = pick_dir(rise);
                    extra    = extra_rises(rise);
                    lock_n   = LOCK_LOAD;
                    state_n  = LOCK;
                end else if (repeat_fire) begin
`ifdef AUTOREPEAT_EN
                    push_dir = last_dir;
`endif
                    push_req = 1'b1;
                    lock_n   = LOCK_LOAD;
                    state_n  = LOCK;
                end
            end
            LOCK: begin
                if (lock_cnt == '0) state_n = ARMED;
                else                lock_n  = lock_cnt - 1'b1;
            end
            HALT:    state_n = HALT;
            default: state_n = HALT;
        endcase
        // game_over wins over this cycle's press: nothing pushed, nothing counted.
        if (game_over) begin
            state_n  = HALT;
            push_req = 1'b0;
            extra    = 2'd0;
        end
    end

    assign pop       = cmd_valid & cmd_ready & ~game_over;
    assign push      = push_req & (~full | pop);
    assign push_drop = push_req & full & ~pop;
    assign drop_sum  = {1'b0, drop_cnt} + {7'b0, extra} + {8'b0, push_drop};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARMED;
            lock_cnt <= '0;
            prev     <= 4'b1111;
            drop_cnt <= 8'd0;
        end else begin
            state    <= state_n;
            lock_cnt <= lock_n;
            prev     <= btn;
            drop_cnt <= (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
        end
    end

    cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (3)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (game_over),
        .din   (push_dir),
        .dout  (head),
        .count (q_count),
        .full  (full),
        .empty (empty)
    );

    assign cmd_valid = ~empty;
    assign cmd_dir   = empty ? DIR_NONE : head;

endmodule

// File: tb/tb_move_cmd_scheduler.sv
// Bench for move_cmd_scheduler: directed scenarios plus randomized button
// traffic, checked by a queue-based reference model and a negedge monitor.
module tb_move_cmd_scheduler;
    import game_pkg::*;

    localparam int DEPTH   = 4;
    localparam int LOCKOUT = 8;
    localparam int REPEAT  = 1024;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   up;
    logic                   down;
    logic                   left;
    logic                   right;
    logic                   game_over;
    logic                   cmd_ready;
    logic                   cmd_valid;
    logic [2:0]             cmd_dir;
    logic [$clog2(DEPTH):0] q_count;
    logic [7:0]             drop_cnt;
    sched_state_t           state;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [2:0] exp_q[$];
    logic [2:0] model_q[$];
    logic [3:0] m_prev;
    int         m_blind;
    bit         m_halt;
    int         m_drop;

    move_cmd_scheduler #(
        .DEPTH   (DEPTH),
        .LOCKOUT (LOCKOUT),
        .REPEAT  (REPEAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .up        (up),
        .down      (down),
        .left      (left),
        .right     (right),
        .game_over (game_over),
        .cmd_ready (cmd_ready),
        .cmd_valid (cmd_valid),
        .cmd_dir   (cmd_dir),
        .q_count   (q_count),
        .drop_cnt  (drop_cnt),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_dut();
        {up, down, left, right} = 4'b0;
        game_over = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic press(input int idx);
        case (idx)
            0: up = 1'b1;
            1: down = 1'b1;
            2: left = 1'b1;
            default: right = 1'b1;
        endcase
        step();
        {up, down, left, right} = 4'b0;
    endtask

    // Reference model: one command per accepted press, LOCKOUT blind edges
    // afterwards, a bounded queue of commands, and a halt on game_over.
    always @(posedge clk) begin
        logic [3:0] b;
        logic [3:0] r;
        logic [2:0] d;
        b = {right, left, down, up};
        if (rst) begin
            m_prev  = 4'hf;
            m_blind = 0;
            m_halt  = 0;
            m_drop  = 0;
            model_q.delete();
            exp_q.delete();
        end else begin
            r = b & ~m_prev;
            m_prev = b;
            if (m_halt) begin
                m_halt = 1;
            end else if (game_over) begin
                m_halt = 1;
                model_q.delete();
                exp_q.delete();
            end else begin
                if (model_q.size() > 0 && cmd_ready) void'(model_q.pop_front());
                if (m_blind > 0) begin
                    m_blind--;
                end else if (r != 4'b0) begin
                    m_drop += $countones(r) - 1;
                    d = r[0] ? 3'd1 : r[1] ? 3'd2 : r[2] ? 3'd3 : 3'd4;
                    if (model_q.size() < DEPTH) begin
                        model_q.push_back(d);
                        exp_q.push_back(d);
                    end else begin
                        m_drop++;
                    end
                    m_blind = LOCKOUT;
                end
                if (m_drop > 255) m_drop = 255;
            end
        end
    end

    // Monitor: compares visible outputs against the expected queue each cycle.
    always @(negedge clk) begin
        if (!rst) begin
            cmp("q_count", 32'(q_count), 32'(exp_q.size()));
            cmp("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            cmp("cmd_valid", 32'(cmd_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() == 0) cmp("cmd_dir_idle", 32'(cmd_dir), 32'd0);
            else                   cmp("cmd_dir_head", 32'(cmd_dir), 32'(exp_q[0]));
            if (cmd_valid && cmd_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        end
    end

    initial begin
        int ready_pct;
        rst = 1'b1;
        {up, down, left, right} = 4'b0;
        game_over = 1'b0;
        cmd_ready = 1'b0;

        // Button held through reset must not fire.
        up = 1'b1;
        step();
        step();
        step();
        rst = 1'b0;
        cmp("rst_q_count", 32'(q_count), 32'd0);
        cmp("rst_valid", 32'(cmd_valid), 32'd0);
        cmp("rst_dir", 32'(cmd_dir), 32'd0);
        cmp("rst_drop", 32'(drop_cnt), 32'd0);
        cmp("rst_state", 32'(state), 32'(ARMED));
        repeat (20) step();
        cmp("held_no_cmd", 32'(q_count), 32'd0);
        up = 1'b0;
        step();
        up = 1'b1;
        step();
        cmp("latency_valid", 32'(cmd_valid), 32'd1);
        cmp("latency_dir", 32'(cmd_dir), 32'(DIR_UP));
        up = 1'b0;
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        cmp("pop_empty", 32'(cmd_valid), 32'd0);

        // Simultaneous rises: UP wins, one drop.
        reset_dut();
        up = 1'b1;
        right = 1'b1;
        step();
        {up, right} = 2'b0;
        cmp("arb_dir", 32'(cmd_dir), 32'(DIR_UP));
        cmp("arb_drop", 32'(drop_cnt), 32'd1);
        cmp("arb_count", 32'(q_count), 32'd1);

        // Back-pressure: two queued commands, head stable, then drained in order.
        reset_dut();
        press(2);
        repeat (9) step();
        press(3);
        cmp("bp_count", 32'(q_count), 32'd2);
        cmp("bp_head", 32'(cmd_dir), 32'(DIR_LEFT));
        repeat (3) step();
        cmp("bp_stable", 32'(cmd_dir), 32'(DIR_LEFT));
        cmd_ready = 1'b1;
        step();
        cmp("bp_pop1", 32'(cmd_dir), 32'(DIR_RIGHT));
        step();
        cmd_ready = 1'b0;
        cmp("bp_drained", 32'(cmd_valid), 32'd0);

        // Full FIFO: fifth press dropped, press with a pop accepted.
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            press(i % 4);
            repeat (LOCKOUT + 1) step();
        end
        cmp("full_count", 32'(q_count), 32'd4);
        cmp("full_drop", 32'(drop_cnt), 32'd1);
        up = 1'b1;
        cmd_ready = 1'b1;
        step();
        up = 1'b0;
        cmd_ready = 1'b0;
        cmp("full_pop_push_count", 32'(q_count), 32'd4);
        cmp("full_pop_push_drop", 32'(drop_cnt), 32'd1);
        cmp("full_pop_push_head", 32'(cmd_dir), 32'(DIR_DOWN));

        // Press inside lockout is ignored and not counted.
        reset_dut();
        press(1);
        step();
        step();
        press(0);
        repeat (LOCKOUT) step();
        cmp("lock_count", 32'(q_count), 32'd1);
        cmp("lock_dir", 32'(cmd_dir), 32'(DIR_DOWN));
        cmp("lock_drop", 32'(drop_cnt), 32'd0);

        // game_over with a press: flush, halt, ignore later presses.
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            press(i);
            repeat (LOCKOUT + 1) step();
        end
        cmp("go_pre_count", 32'(q_count), 32'd3);
        up = 1'b1;
        game_over = 1'b1;
        step();
        up = 1'b0;
        game_over = 1'b0;
        cmp("go_valid", 32'(cmd_valid), 32'd0);
        cmp("go_count", 32'(q_count), 32'd0);
        cmp("go_state", 32'(state), 32'(HALT));
        press(1);
        repeat (LOCKOUT + 2) step();
        press(2);
        step();
        cmp("go_ignored", 32'(q_count), 32'd0);

        // Randomized traffic.
        reset_dut();
        ready_pct = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) ready_pct = (i / 500 % 3 == 0) ? 10 : (i / 500 % 3 == 1) ? 50 : 90;
            cmd_ready = ($urandom_range(0, 99) < ready_pct);
            if ($urandom_range(0, 11) == 0) up = ~up;
            if ($urandom_range(0, 11) == 0) down = ~down;
            if ($urandom_range(0, 11) == 0) left = ~left;
            if ($urandom_range(0, 11) == 0) right = ~right;
            if ($urandom_range(0, 1499) == 0) begin
                game_over = 1'b1;
                step();
                game_over = 1'b0;
                repeat (5) step();
                reset_dut();
            end else begin
                step();
            end
        end

        // Bounded drain.
        {up, down, left, right} = 4'b0;
        cmd_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
        step();
        cmp("drain_empty", 32'(exp_q.size()), 32'd0);
        cmp("drain_valid", 32'(cmd_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/move_cmd_scheduler.md
Name: move_cmd_scheduler

Overview:
- Sits between the four button inputs and the game-engine FSM.
- Converts button presses into one direction command per press: rising-edge detect, lockout, priority arbitration.
- Queues commands in a small FIFO and hands them to the engine over a valid/ready handshake.
- Stops issuing commands once the engine reports game over.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- LOCKOUT, 8, cycles after an accepted press during which all new presses are ignored; minimum 1.
- REPEAT, 1024, hold cycles before an auto-repeat command is issued (used only with AUTOREPEAT_EN).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- up  in  1  button level, already synchronised.
- down  in  1  button level, already synchronised.
- left  in  1  button level, already synchronised.
- right  in  1  button level, already synchronised.
- game_over  in  1  level from engine; win or no-move reached.
- cmd_ready  in  1  engine is in its input state and can take a command.
- cmd_valid  out  1  head of FIFO is valid.
- cmd_dir  out  3  direction: 001 UP, 010 DOWN, 011 LEFT, 100 RIGHT; 000 when not valid.
- q_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- drop_cnt  out  8  saturating count of presses lost to arbitration or a full FIFO.

Behaviour:
- Reset:
  - State ARMED; FIFO empty; cmd_valid=0, cmd_dir=000, q_count=0, drop_cnt=0.
  - Previous-button register set to 4'b1111, so a button held through reset does not fire.
- Edge detect: per-button rise = level & ~prev. prev updates every cycle in every state.
- States:
  - ARMED: if any rise, select one by priority UP > DOWN > LEFT > RIGHT.
    - Push the selected direction to the FIFO at this clock edge.
    - Load the lockout counter with LOCKOUT-1 and go to LOCK.
    - Each extra simultaneous rise adds 1 to drop_cnt.
  - LOCK: rises are ignored and not counted. Counter decrements each cycle; at 0 return to ARMED. Net effect: exactly LOCKOUT cycles are blind.
  - HALT: entered from any state when game_over=1 at a clock edge.
    - FIFO is flushed on that edge; cmd_valid=0 from the next cycle.
    - No pushes or pops occur. Left only by rst.
- Latency: a rise sampled at edge k makes cmd_valid=1 in the cycle after edge k (1 cycle) when the FIFO was empty.
- Handshake:
  - A pop occurs when cmd_valid & cmd_ready.
  - While cmd_valid=1 and cmd_ready=0, cmd_dir must remain stable.
  - cmd_valid never deasserts without a pop, except on HALT or rst.
- FIFO boundaries:
  - Full with no pop: the push is dropped and drop_cnt increments. The lockout is still entered.
  - Full with a pop in the same cycle: the push is accepted and q_count stays DEPTH.
  - Empty: a pop cannot occur; cmd_dir=000.
  - Read and write pointers wrap modulo DEPTH. q_count is never greater than DEPTH.
- drop_cnt saturates at 255.
- Simultaneous events: game_over has priority over push and pop in the same cycle; that cycle's push is discarded and not counted. rst has priority over everything.

Optional Feature:
- AUTOREPEAT_EN defined:
  - In ARMED, if the last accepted button is still held, a hold counter runs.
  - After REPEAT cycles of continuous hold, the same direction is pushed again, then LOCK, and the hold counter restarts.
  - Releasing the button or pressing another clears the hold counter.
- AUTOREPEAT_EN undefined: a held button produces exactly one command; the hold counter and the REPEAT logic are absent.

Decomposition:
- Shared package game_pkg:
  - Direction codes DIR_NONE/UP/DOWN/LEFT/RIGHT (3-bit).
  - Scheduler state enum ARMED/LOCK/HALT.
  - Tile width constant (4).
  - The engine FSM reuses the direction codes from this package.
- One sub-module, cmd_fifo: parameterised DEPTH×3-bit synchronous FIFO with push, pop, flush, count, full and empty.

Test Plan:
- Reset with up held, then hold 20 cycles -> no command, q_count=0; release, press up -> cmd_valid=1 with cmd_dir=001 one cycle after the first high sample.
- up and right rise in the same cycle -> single command 001 queued, drop_cnt=1.
- cmd_ready=0; press left, then right, spaced 10 cycles apart -> q_count=2, head 011 held stable; ready for 2 cycles -> pops 011 then 100, then cmd_valid=0.
- cmd_ready=0, DEPTH=4; 5 presses spaced LOCKOUT+2 cycles apart -> q_count=4, drop_cnt=1; next press in a cycle with a pop -> accepted, q_count stays 4.
- Press down, press up 3 cycles later (LOCKOUT=8) -> only 010 queued, drop_cnt unchanged.
- 3 entries queued, assert game_over for 1 cycle together with a press -> next cycle cmd_valid=0 and q_count=0; later presses ignored until rst.
